log_mult_k_pipe: RTL and testbench

- Pipelined, parametrised Mitchell-style logarithmic multiplier with K-bit truncated mantissa.
- Per-transaction choice of unsigned or ones'-complement signed operands.
- Valid/ready handshake on both sides with full backpressure.
- Sits between operand FIFOs and accumulator/datapath logic; 3-cycle latency, one result per cycle when unstalled.

---
 rtl/log_mult_pkg.sv | 26 ++
 rtl/log_mult_lod_norm.sv | 35 +++
 rtl/log_mult_k_pipe.sv | 137 +++++++++++++
 tb/tb_log_mult_k_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log_mult_pkg.sv
// rtl/log_mult_pkg.sv - shared widths, flag payload and default K for the log multiplier
// Purpose: widths of the log operand and of the log sum, the sign/zero flag
//          payload carried through every pipeline stage, and the default K.
// Ports:   none (package).
package log_mult_pkg;

  localparam int K_DEFAULT = 5;

  // Log operand is {leading-one position, truncated fraction}.
  function automatic int log_w(input int log_n, input int k);
    return log_n + k;
  endfunction

  // One extra bit so the sum of two log operands never overflows.
  function automatic int sum_w(input int log_n, input int k);
    return log_n + k + 1;
  endfunction

  typedef struct packed {
    logic sa;
    logic sb;
    logic za;
    logic zb;
  } flags_t;

endpackage

// File: rtl/log_mult_lod_norm.sv
// rtl/log_mult_lod_norm.sv - leading-one detector and fraction normaliser
// Purpose: for a magnitude, find the leading-one position k, the bits below it
//          left-aligned into N-1 bits and truncated to K bits, and a zero flag.
// Ports:   mag  in  N      magnitude
//          k    out LOG_N  leading-one index (0 when mag is zero)
//          frac out K      truncated normalised fraction
//          zero out 1      mag == 0
module log_mult_lod_norm #(
  parameter int N     = 8,
  parameter int LOG_N = 3,
  parameter int K     = 5
) (
  input  logic [N-1:0]     mag,
  output logic [LOG_N-1:0] k,
  output logic [K-1:0]     frac,
  output logic             zero
);

  logic [N-1:0] shifted;

  always_comb begin
    k = '0;
    for (int i = 0; i < N; i++) begin
      if (mag[i]) k = LOG_N'(i);
    end
  end

  assign zero = (mag == '0);

  // Move the leading one to bit N-1; bits N-2 downwards are the fraction,
  // of which the top K survive.
  assign shifted = mag << (LOG_N'(N - 1) - k);
  assign frac    = K'(shifted >> (N - 1 - K));

endmodule

// File: rtl/log_mult_k_pipe.sv
// rtl/log_mult_k_pipe.sv - 3-stage Mitchell logarithmic multiplier with valid/ready
// Purpose: approximate a*b as antilog(log a + log b) with a K-bit mantissa,
//          unsigned or ones'-complement signed per transaction, full backpressure.
// Ports:   clk, rst_n            clock, async active-low reset
//          in_valid/in_ready     operand handshake
//          in_a, in_b, in_signed operands and signedness
//          out_valid/out_ready   result handshake
//          out_z                 2N-bit product approximation
module log_mult_k_pipe
  import log_mult_pkg::*;
#(
  parameter int N     = 8,
  parameter int LOG_N = 3,
  parameter int K     = K_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  input  logic           in_signed,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_z
);

  localparam int LW = log_w(LOG_N, K);
  localparam int SW = sum_w(LOG_N, K);
  localparam int PW = 2 * N + K + 1;

  typedef struct packed {
    flags_t          f;
    logic [LW-1:0]   la;
    logic [LW-1:0]   lb;
  } s1_t;

  typedef struct packed {
    flags_t          f;
    logic [SW-1:0]   sum;
  } s2_t;

  logic v1, v2, v3;
  logic adv1, adv2, adv3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [2*N-1:0] z_d, z_q;

  // Handshake: a stage may load when empty or when the next stage loads,
  // so ready ripples back combinationally from out_ready without a bubble.
  assign adv3     = ~v3 | out_ready;
  assign adv2     = ~v2 | adv3;
  assign adv1     = ~v1 | adv2;
  assign in_ready = adv1;

  // S1 front end: sign, magnitude, leading one, fraction, zero flag.
  logic             sa, sb, za, zb;
  logic [N-1:0]     ma, mb;
  logic [LOG_N-1:0] ka, kb;
  logic [K-1:0]     fa, fb;

  assign sa = in_signed & in_a[N-1];
  assign sb = in_signed & in_b[N-1];
  assign ma = sa ? ~in_a : in_a;
  assign mb = sb ? ~in_b : in_b;

  log_mult_lod_norm #(.N(N), .LOG_N(LOG_N), .K(K)) u_lod_a (
    .mag  (ma),
    .k    (ka),
    .frac (fa),
    .zero (za)
  );

  log_mult_lod_norm #(.N(N), .LOG_N(LOG_N), .K(K)) u_lod_b (
    .mag  (mb),
    .k    (kb),
    .frac (fb),
    .zero (zb)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.f.sa = sa;
    s1_d.f.sb = sb;
    s1_d.f.za = za;
    s1_d.f.zb = zb;
    s1_d.la   = {ka, fa};
    s1_d.lb   = {kb, fb};
  end

  // S2 front end: log-domain add.
  always_comb begin
    s2_d     = '0;
    s2_d.f   = s1_q.f;
    s2_d.sum = SW'(s1_q.la) + SW'(s1_q.lb);
  end

  // S3 front end: antilog, sign restore, zero mask.
  logic [LOG_N:0]   e;
  logic [K-1:0]     f;
  logic [PW-1:0]    p_wide;
  logic [2*N-1:0]   p;

  assign e      = s2_q.sum[SW-1:K];
  assign f      = s2_q.sum[K-1:0];
  assign p_wide = PW'({1'b1, f}) << e;
  assign p      = (2*N)'(p_wide >> K);

  always_comb begin
    z_d = (s2_q.f.sa ^ s2_q.f.sb) ? ~p : p;
    if (s2_q.f.za | s2_q.f.zb) z_d = '0;
  end

  // Valid bits and payloads; payloads only move when real data moves,
  // which keeps out_z stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
      z_q  <= '0;
    end else begin
      if (adv1) v1 <= in_valid;
      if (adv2) v2 <= v1;
      if (adv3) v3 <= v2;
      if (adv1 & in_valid) s1_q <= s1_d;
      if (adv2 & v1)       s2_q <= s2_d;
      if (adv3 & v2)       z_q  <= z_d;
    end
  end

  assign out_valid = v3;
  assign out_z     = z_q;

endmodule

// File: tb/tb_log_mult_k_pipe.sv
// tb/tb_log_mult_k_pipe.sv - scoreboard bench for log_mult_k_pipe at N=8/K=5 and N=16/K=8
module tb_log_mult_k_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [7:0]  in_a, in_b;
  logic [15:0] out_z;

  logic        in_valid16, in_ready16, in_signed16, out_valid16, out_ready16;
  logic [15:0] in_a16, in_b16;
  logic [31:0] out_z16;

  int checks = 0;
  int errors = 0;

  logic [15:0] q8[$];
  logic [31:0] q16[$];
  bit   bp_en = 0;
  logic or_fixed = 1'b1;

  log_mult_k_pipe #(.N(8), .LOG_N(3), .K(5)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z)
  );

  log_mult_k_pipe #(.N(16), .LOG_N(4), .K(8)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .in_a(in_a16), .in_b(in_b16), .in_signed(in_signed16),
    .out_valid(out_valid16), .out_ready(out_ready16), .out_z(out_z16)
  );

  // Reference: Mitchell log with truncated fraction, integer arithmetic.
  function automatic longint lg(int n, int kk, longint m);
    int k = 0;
    for (int i = 0; i < n; i++) if (((m >> i) & 1) != 0) k = i;
    return (longint'(k) << kk) + (((m - (longint'(1) << k)) << (n - 1 - k)) >> (n - 1 - kk));
  endfunction

  function automatic longint model(int n, int kk, longint a, longint b, bit sgn);
    longint mask  = (longint'(1) << n) - 1;
    longint mask2 = (longint'(1) << (2 * n)) - 1;
    bit sa = sgn && (((a >> (n - 1)) & 1) != 0);
    bit sb = sgn && (((b >> (n - 1)) & 1) != 0);
    longint ma = sa ? (~a & mask) : a;
    longint mb = sb ? (~b & mask) : b;
    longint s, e, f, p;
    if (ma == 0 || mb == 0) return 0;
    s = lg(n, kk, ma) + lg(n, kk, mb);
    e = s >> kk;
    f = s & ((longint'(1) << kk) - 1);
    p = (((longint'(1) << kk) + f) << e) >> kk;
    p = p & mask2;
    if (sa ^ sb) p = ~p & mask2;
    return p;
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : or_fixed;
    end
  end

  logic        prev_stall = 1'b0;
  logic [15:0] prev_z;
  logic [15:0] e8;
  logic [31:0] e16;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (in_ready !== !(q8.size() == 3 && !out_ready)) begin
        errors++;
        $display("FAIL in_ready actual %b required %b (inflight %0d out_ready %b)",
                 in_ready, !(q8.size() == 3 && !out_ready), q8.size(), out_ready);
      end
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_z !== prev_z) begin
          errors++;
          $display("FAIL stall_hold actual valid %b z %h required valid 1 z %h", out_valid, out_z, prev_z);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q8.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out8 actual z %h required no output", out_z);
        end else begin
          e8 = q8.pop_front();
          if (out_z !== e8) begin
            errors++;
            $display("FAIL result8 actual %h required %h", out_z, e8);
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_z     = out_z;
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid16) begin
      checks++;
      if (q16.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out16 actual z %h required no output", out_z16);
      end else begin
        e16 = q16.pop_front();
        if (out_z16 !== e16) begin
          errors++;
          $display("FAIL result16 actual %h required %h", out_z16, e16);
        end
      end
    end
  end

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] exp);
    int tries = 0;
    bit done = 0;
    in_a = a; in_b = b; in_signed = s; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      if (done) q8.push_back(exp);
      #1;
      tries++;
      if (!done && tries > 200) begin
        checks++; errors++;
        $display("FAIL send8_timeout actual no accept required accept within 200 cycles");
        done = 1;
      end
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [31:0] exp);
    int tries = 0;
    bit done = 0;
    in_a16 = a; in_b16 = b; in_signed16 = s; in_valid16 = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = in_ready16;
      @(posedge clk);
      if (done) q16.push_back(exp);
      #1;
      tries++;
      if (!done && tries > 200) begin
        checks++; errors++;
        $display("FAIL send16_timeout actual no accept required accept within 200 cycles");
        done = 1;
      end
    end
    in_valid16 = 1'b0;
  endtask

  task automatic drain;
    int t = 0;
    in_valid = 1'b0;
    in_valid16 = 1'b0;
    do begin
      @(posedge clk);
      t++;
    end while ((q8.size() > 0 || q16.size() > 0) && t < 300);
    #1;
    checks++;
    if (q8.size() != 0 || q16.size() != 0) begin
      errors++;
      $display("FAIL drain actual pending %0d/%0d required 0/0", q8.size(), q16.size());
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (out_valid !== 1'b0 || out_z !== 16'h0) begin
      errors++;
      $display("FAIL reset8 actual valid %b z %h required valid 0 z 0000", out_valid, out_z);
    end
    checks++;
    if (out_valid16 !== 1'b0 || out_z16 !== 32'h0) begin
      errors++;
      $display("FAIL reset16 actual valid %b z %h required valid 0 z 0", out_valid16, out_z16);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_latency;
    in_a = 8'd3; in_b = 8'd5; in_signed = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    q8.push_back(16'd14);
    #1 in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 3)) begin
        errors++;
        $display("FAIL latency cycle %0d actual valid %b required %b", c, out_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (out_z !== 16'd14) begin
          errors++;
          $display("FAIL latency_z actual %h required 000e", out_z);
        end
      end
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_arith8;
    send8(8'd4,   8'd4,   1'b0, 16'd16);
    send8(8'hFC,  8'h05,  1'b1, 16'hFFF1);
    send8(8'hFC,  8'h05,  1'b0, 16'(model(8, 5, 252, 5, 0)));
    send8(8'd0,   8'd200, 1'b0, 16'h0000);
    send8(8'hFF,  8'h85,  1'b1, 16'h0000);
    send8(8'd255, 8'd255, 1'b0, 16'hF800);
    send8(8'h80,  8'h40,  1'b0, 16'h2000);
    send8(8'hFE,  8'h04,  1'b1, 16'hFFFB);
    send8(8'h7F,  8'h00,  1'b1, 16'h0000);
    drain();
  endtask

  task automatic test_arith16;
    logic [15:0] a, b;
    logic s;
    send16(16'd3,    16'd5,    1'b0, 32'd14);
    send16(16'd4,    16'd4,    1'b0, 32'd16);
    send16(16'hFFFC, 16'h0005, 1'b1, 32'hFFFF_FFF1);
    send16(16'd0,    16'd200,  1'b0, 32'h0);
    send16(16'hFFFF, 16'h8005, 1'b1, 32'h0);
    send16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFF00_0000);
    send16(16'hFFFC, 16'h0005, 1'b0, 32'(model(16, 8, 16'hFFFC, 5, 0)));
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      send16(a, b, s, 32'(model(16, 8, a, b, s)));
    end
    drain();
  endtask

  task automatic test_backpressure;
    logic [7:0] a, b;
    logic s;
    bp_en = 1;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      send8(a, b, s, 16'(model(8, 5, a, b, s)));
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bp_en = 0;
    drain();
  endtask

  task automatic test_back_to_back;
    logic [11:0] ov;
    logic [7:0]  a, b;
    ov = '0;
    for (int c = 0; c < 12; c++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if (c < 8) begin
        in_a = a; in_b = b; in_signed = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      ov[c] = out_valid;
      if (c < 8) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_in_ready cycle %0d actual %b required 1", c, in_ready);
        end
      end
      @(posedge clk);
      if (c < 8) q8.push_back(16'(model(8, 5, a, b, 0)));
      #1;
    end
    checks++;
    if (ov !== 12'h7F8) begin
      errors++;
      $display("FAIL b2b_valid_pattern actual %b required %b", ov, 12'h7F8);
    end
    drain();
  endtask

  task automatic test_reset_mid;
    send8(8'd10, 8'd20, 1'b0, 16'(model(8, 5, 10, 20, 0)));
    send8(8'd30, 8'd40, 1'b0, 16'(model(8, 5, 30, 40, 0)));
    send8(8'd50, 8'd60, 1'b0, 16'(model(8, 5, 50, 60, 0)));
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    q8.delete();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_z !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid actual valid %b z %h required valid 0 z 0000", out_valid, out_z);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stale_after_reset cycle %0d actual valid %b required 0", c, out_valid);
      end
    end
    @(posedge clk);
    #1;
    send8(8'd3, 8'd5, 1'b0, 16'd14);
    drain();
  endtask

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout actual still running required finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_signed16 = 1'b0;
    out_ready16 = 1'b1;
    test_reset();
    test_latency();
    test_arith8();
    test_arith16();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
